// File: rtl/full_st1_feed_pkg.sv
// full_st1_feed_pkg: shared word type, FSM states and parameter defaults for the feed driver
package full_st1_feed_pkg;

    typedef logic [31:0] float_24_8;

    typedef enum logic [1:0] {
        IDLE,
        TAP,
        WAIT_LOAD,
        DATA
    } feed_state_t;

    localparam int TAP_WORDS_DEF  = 6;
    localparam int DATA_WORDS_DEF = 6;
    localparam int ADDR_W_DEF     = 6;

    // index width needed to address a buffer of the given depth
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/full_st1_feed_buf.sv
// full_st1_feed_buf: word buffer with synchronous write and asynchronous read, out-of-range writes dropped
module full_st1_feed_buf
    import full_st1_feed_pkg::*;
#(
    parameter int DEPTH  = 6,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  float_24_8         i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output float_24_8         o_rdata
);

    localparam int IW = idx_w(DEPTH);

    float_24_8 r_mem [0:(1<<IW)-1];
    logic      w_wr_ok;

    assign w_wr_ok = i_we && (i_waddr < ADDR_W'(DEPTH));

    // storage is deliberately not reset so contents survive a run abort
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[i_waddr[IW-1:0]] <= i_wdata;
    end

    assign o_rdata = (i_raddr < ADDR_W'(DEPTH)) ? r_mem[i_raddr[IW-1:0]] : '0;

endmodule

// File: rtl/full_st1_feed.sv
// full_st1_feed: streams a buffered tap vector, waits for load_finish, then streams the data vector num_vec+1 times
module full_st1_feed
    import full_st1_feed_pkg::*;
#(
    parameter int TAP_WORDS  = TAP_WORDS_DEF,
    parameter int DATA_WORDS = DATA_WORDS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_wr_en,
    input  logic              i_wr_sel,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  float_24_8         i_wr_data,
    input  logic              i_start,
    input  logic              i_tap_en,
    input  logic [7:0]        i_num_vec,
    input  logic              i_load_finish,
    output float_24_8         o_tap_in,
    output logic              o_tap_in_fst,
    output logic              o_tap_in_vld,
    input  logic              i_tap_in_rdy,
    output float_24_8         o_stage_1_data,
    output logic              o_stage_1_data_fst,
    output logic              o_stage_1_data_vld,
    input  logic              i_stage_1_data_rdy,
    output logic              o_busy,
    output logic              o_done
);

    feed_state_t       r_state, w_state;
    logic [7:0]        r_num_vec, w_num_vec;
    logic [7:0]        r_vec, w_vec;
    logic [ADDR_W-1:0] r_word, w_word;
    logic              r_load_seen, w_load_seen;
    logic              r_done, w_done;
    float_24_8         r_tap_word, w_tap_word;
    logic              r_tap_fst, w_tap_fst;
    logic              r_tap_vld, w_tap_vld;
    float_24_8         r_dat_word, w_dat_word;
    logic              r_dat_fst, w_dat_fst;
    logic              r_dat_vld, w_dat_vld;

    logic              w_busy;
    logic              w_wr_ok;
    logic              w_tap_last, w_dat_last;
    logic [ADDR_W-1:0] w_tap_ra, w_dat_ra;
    float_24_8         w_tap_rd, w_dat_rd;

    assign w_busy     = (r_state != IDLE);
    // the start cycle also freezes the buffers so word 0 is read consistently
    assign w_wr_ok    = i_wr_en && !w_busy && !i_start;
    assign w_tap_last = (r_word == ADDR_W'(TAP_WORDS - 1));
    assign w_dat_last = (r_word == ADDR_W'(DATA_WORDS - 1));
    // read address is the word that follows the one on the output, wrapping to 0
    assign w_tap_ra   = (r_state == TAP && !w_tap_last) ? r_word + 1'b1 : '0;
    assign w_dat_ra   = (r_state == DATA && !w_dat_last) ? r_word + 1'b1 : '0;

    full_st1_feed_buf #(
        .DEPTH  (TAP_WORDS),
        .ADDR_W (ADDR_W)
    ) u_tap_buf (
        .i_clk   (i_clk),
        .i_we    (w_wr_ok && i_wr_sel),
        .i_waddr (i_wr_addr),
        .i_wdata (i_wr_data),
        .i_raddr (w_tap_ra),
        .o_rdata (w_tap_rd)
    );

    full_st1_feed_buf #(
        .DEPTH  (DATA_WORDS),
        .ADDR_W (ADDR_W)
    ) u_dat_buf (
        .i_clk   (i_clk),
        .i_we    (w_wr_ok && !i_wr_sel),
        .i_waddr (i_wr_addr),
        .i_wdata (i_wr_data),
        .i_raddr (w_dat_ra),
        .o_rdata (w_dat_rd)
    );

    // next-state, counters and next output words; output registers only move on a transfer
    always_comb begin
        w_state     = r_state;
        w_num_vec   = r_num_vec;
        w_vec       = r_vec;
        w_word      = r_word;
        w_load_seen = r_load_seen || (w_busy && i_load_finish);
        w_done      = 1'b0;
        w_tap_word  = r_tap_word;
        w_tap_fst   = r_tap_fst;
        w_tap_vld   = r_tap_vld;
        w_dat_word  = r_dat_word;
        w_dat_fst   = r_dat_fst;
        w_dat_vld   = r_dat_vld;
        unique case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_num_vec   = i_num_vec;
                    w_load_seen = 1'b0;
                    w_word      = '0;
                    w_vec       = '0;
                    if (i_tap_en) begin
                        w_state    = TAP;
                        w_tap_vld  = 1'b1;
                        w_tap_fst  = 1'b1;
                        w_tap_word = w_tap_rd;
                    end else begin
                        w_state    = DATA;
                        w_dat_vld  = 1'b1;
                        w_dat_fst  = 1'b1;
                        w_dat_word = w_dat_rd;
                    end
                end
            end
            TAP: begin
                if (r_tap_vld && i_tap_in_rdy) begin
                    w_tap_fst = 1'b0;
                    if (w_tap_last) begin
                        w_tap_vld = 1'b0;
                        w_word    = '0;
                        w_state   = WAIT_LOAD;
                    end else begin
                        w_word     = w_tap_ra;
                        w_tap_word = w_tap_rd;
                    end
                end
            end
            WAIT_LOAD: begin
                if (r_load_seen) begin
                    w_state    = DATA;
                    w_dat_vld  = 1'b1;
                    w_dat_fst  = 1'b1;
                    w_dat_word = w_dat_rd;
                    w_word     = '0;
                    w_vec      = '0;
                end
            end
            DATA: begin
                if (r_dat_vld && i_stage_1_data_rdy) begin
                    w_word     = w_dat_ra;
                    w_dat_word = w_dat_rd;
                    w_dat_fst  = w_dat_last;
                    if (w_dat_last) begin
                        w_vec = r_vec + 1'b1;
                        if (r_vec == r_num_vec) begin
                            w_state   = IDLE;
                            w_dat_vld = 1'b0;
                            w_dat_fst = 1'b0;
                            w_done    = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    // state and output registers; reset aborts any run without a done pulse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_num_vec   <= '0;
            r_vec       <= '0;
            r_word      <= '0;
            r_load_seen <= 1'b0;
            r_done      <= 1'b0;
            r_tap_word  <= '0;
            r_tap_fst   <= 1'b0;
            r_tap_vld   <= 1'b0;
            r_dat_word  <= '0;
            r_dat_fst   <= 1'b0;
            r_dat_vld   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_num_vec   <= w_num_vec;
            r_vec       <= w_vec;
            r_word      <= w_word;
            r_load_seen <= w_load_seen;
            r_done      <= w_done;
            r_tap_word  <= w_tap_word;
            r_tap_fst   <= w_tap_fst;
            r_tap_vld   <= w_tap_vld;
            r_dat_word  <= w_dat_word;
            r_dat_fst   <= w_dat_fst;
            r_dat_vld   <= w_dat_vld;
        end
    end

    assign o_tap_in           = r_tap_word;
    assign o_tap_in_fst       = r_tap_fst;
    assign o_tap_in_vld       = r_tap_vld;
    assign o_stage_1_data     = r_dat_word;
    assign o_stage_1_data_fst = r_dat_fst;
    assign o_stage_1_data_vld = r_dat_vld;
    assign o_busy             = w_busy;
    assign o_done             = r_done;

endmodule

// File: tb/tb_full_st1_feed.sv
// tb_full_st1_feed: scoreboard bench with randomized runs and ready patterns against a word-list model
module tb_full_st1_feed;

    localparam int TW = 6;
    localparam int DW = 6;
    localparam int AW = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0, wr_sel = 1'b0, start = 1'b0, tap_en = 1'b0, load_finish = 1'b0;
    logic        tap_rdy = 1'b1, dat_rdy = 1'b1;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [7:0]  num_vec = '0;
    logic [31:0] tap_in, dat;
    logic        tap_fst, tap_vld, dat_fst, dat_vld, busy, done;

    int total = 0, bad = 0, cyc = 0, pc = 0, done_cnt = 0, dat_xfers = 0, rmode = 0;
    int first_tap = -1, last_tap = -1, first_dat = -1;
    bit run_tap = 1'b0, lf_driven = 1'b0, t_stall = 1'b0, d_stall = 1'b0;
    logic [31:0] tap_m [TW];
    logic [31:0] dat_m [DW];
    logic [32:0] tq[$], dq[$];
    logic [32:0] t_hold, d_hold, em;

    full_st1_feed dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_wr_en            (wr_en),
        .i_wr_sel           (wr_sel),
        .i_wr_addr          (wr_addr),
        .i_wr_data          (wr_data),
        .i_start            (start),
        .i_tap_en           (tap_en),
        .i_num_vec          (num_vec),
        .i_load_finish      (load_finish),
        .o_tap_in           (tap_in),
        .o_tap_in_fst       (tap_fst),
        .o_tap_in_vld       (tap_vld),
        .i_tap_in_rdy       (tap_rdy),
        .o_stage_1_data     (dat),
        .o_stage_1_data_fst (dat_fst),
        .o_stage_1_data_vld (dat_vld),
        .i_stage_1_data_rdy (dat_rdy),
        .o_busy             (busy),
        .o_done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [69:0] got, input logic [69:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, exp);
        end
    endtask

    // ready drivers: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
    initial forever begin
        @(posedge clk);
        #1;
        pc++;
        tap_rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : ((pc % 4 == 0) || (pc % 4 == 3));
        dat_rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom) : ((pc % 4 == 0) || (pc % 4 == 3));
    end

    // monitor: pops expected words on each transfer and checks stall stability and done
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            t_stall = 1'b0;
            d_stall = 1'b0;
        end else begin
            chk("one_vld", {1'b0, tap_vld & dat_vld}, 0);
            if (t_stall) chk("tap_hold", {tap_vld, tap_fst, tap_in}, {1'b1, t_hold});
            if (d_stall) chk("dat_hold", {dat_vld, dat_fst, dat}, {1'b1, d_hold});
            if (dat_vld && first_dat < 0) first_dat = cyc;
            if (dat_vld && run_tap && !lf_driven) begin
                total++;
                bad++;
                $display("FAIL dat_before_load got=%0h want=no data", dat);
            end
            if (tap_vld && tap_rdy) begin
                if (first_tap < 0) first_tap = cyc;
                last_tap = cyc;
                if (tq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tap_extra got=%0h want=none", {tap_fst, tap_in});
                end else begin
                    em = tq.pop_front();
                    chk("tap_word", {tap_fst, tap_in}, em);
                end
            end
            if (dat_vld && dat_rdy) begin
                dat_xfers++;
                if (dq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL dat_extra got=%0h want=none", {dat_fst, dat});
                end else begin
                    em = dq.pop_front();
                    chk("dat_word", {dat_fst, dat}, em);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_state", {busy, 32'(tq.size() + dq.size())}, 0);
            end
            t_stall = tap_vld & !tap_rdy;
            d_stall = dat_vld & !dat_rdy;
            t_hold  = {tap_fst, tap_in};
            d_hold  = {dat_fst, dat};
        end
    end

    task automatic load(input bit sel, input int a, input logic [31:0] d);
        wr_en = 1'b1;
        wr_sel = sel;
        wr_addr = AW'(a);
        wr_data = d;
        if (sel && a < TW) tap_m[a] = d;
        if (!sel && a < DW) dat_m[a] = d;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic run(input bit ten, input int nv, input bit early, input bit junk);
        int n, d0;
        if (ten) for (int i = 0; i < TW; i++) tq.push_back({1'(i == 0), tap_m[i]});
        for (int v = 0; v <= nv; v++) for (int i = 0; i < DW; i++) dq.push_back({1'(i == 0), dat_m[i]});
        run_tap = ten;
        lf_driven = 1'b0;
        first_tap = -1;
        last_tap = -1;
        first_dat = -1;
        d0 = done_cnt;
        start = 1'b1;
        tap_en = ten;
        num_vec = 8'(nv);
        @(posedge clk);
        #1 start = 1'b0;
        tap_en = 1'($urandom);
        num_vec = 8'($urandom);
        chk("busy_rise", busy, 1);
        chk("vld_rise", {tap_vld, dat_vld}, ten ? 2'b10 : 2'b01);
        for (int c = 0; c < 3; c++) begin
            if (junk) begin
                wr_en = 1'b1;
                wr_sel = 1'($urandom);
                wr_addr = AW'($urandom_range(0, DW - 1));
                wr_data = $urandom;
                start = (c == 1);
            end
            if (early && c == 1) begin
                load_finish = 1'b1;
                lf_driven = 1'b1;
            end
            @(posedge clk);
            #1 wr_en = 1'b0;
            start = 1'b0;
            load_finish = 1'b0;
        end
        if (ten && !early) begin
            n = 0;
            while (tq.size() != 0 && n < 2000) begin
                @(negedge clk);
                n++;
            end
            repeat (1 + $urandom_range(0, 3)) @(posedge clk);
            #1 lf_driven = 1'b1;
            load_finish = 1'b1;
            @(posedge clk);
            #1 load_finish = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("done_once", done_cnt - d0, 1);
        chk("q_empty", tq.size() + dq.size(), 0);
        if (ten && early) chk("early_gap", first_dat - last_tap, 2);
        if (ten && rmode == 0) chk("tap_burst", last_tap - first_tap, TW - 1);
        tq.delete();
        dq.delete();
    endtask

    initial begin
        int n, d0;
        #1 rst_n = 1'b0;
        #1 chk("reset_out", {tap_in, tap_fst, tap_vld, dat, dat_fst, dat_vld, busy, done}, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            load(1'b1, i, 32'(i + 1));
            load(1'b0, i, 32'(i + 10));
        end
        load(1'b1, 6, 32'hdead);
        load(1'b0, 7, 32'hbeef);
        rmode = 0;
        run(1'b1, 0, 1'b0, 1'b0);
        run(1'b0, 2, 1'b0, 1'b0);
        rmode = 2;
        run(1'b1, 1, 1'b0, 1'b0);
        run(1'b0, 2, 1'b0, 1'b0);
        rmode = 0;
        run(1'b1, 0, 1'b1, 1'b0);
        rmode = 1;
        run(1'b1, 1, 1'b1, 1'b0);
        rmode = 0;
        run(1'b0, 1, 1'b0, 1'b1);
        run(1'b1, 0, 1'b0, 1'b1);
        // abort a data-only run while word 3 is on the output
        for (int v = 0; v < 2; v++) for (int i = 0; i < DW; i++) dq.push_back({1'(i == 0), dat_m[i]});
        run_tap = 1'b0;
        dat_xfers = 0;
        start = 1'b1;
        tap_en = 1'b0;
        num_vec = 8'd1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (dat_xfers < 3 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("word3_before_reset", {dat_vld, dat}, {1'b1, dat_m[3]});
        d0 = done_cnt;
        rst_n = 1'b0;
        #1 chk("reset_midrun", {tap_in, tap_fst, tap_vld, dat, dat_fst, dat_vld, busy, done}, 0);
        tq.delete();
        dq.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("no_done_abort", done_cnt - d0, 0);
        run(1'b0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) load(1'($urandom), $urandom_range(0, 9), $urandom);
            rmode = $urandom_range(0, 2);
            run(1'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
